// File: rtl/downmem_responder_pkg.sv
// Shared types for the downstream cancelled-order cache and its backing memory.
// Optional build macro: DOWNMEM_SAT_EN (saturating lane accumulate).
package cache_def;

  localparam int unsigned DOWNMEM_LANES  = 4;
  localparam int unsigned DOWNMEM_LANE_W = 32;

  typedef struct packed {
    logic         valid;
    logic         rw;
    logic [31:0]  addr;
    logic [31:0]  wraddr;
    logic [127:0] data;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_WAIT
  } downmem_state_t;

endpackage

// File: rtl/downmem_responder_lane_acc.sv
// Per-lane 32-bit accumulate of a 128-bit line; no carry crosses lanes.
// DOWNMEM_SAT_EN: lanes clamp at all-ones and report saturation on sat.
module downmem_lane_acc
  import cache_def::*;
(
  input  logic [DOWNMEM_LANES*DOWNMEM_LANE_W-1:0] old_line,
  input  logic [DOWNMEM_LANES*DOWNMEM_LANE_W-1:0] delta,
  output logic [DOWNMEM_LANES*DOWNMEM_LANE_W-1:0] sum
`ifdef DOWNMEM_SAT_EN
  ,
  output logic                                    sat
`endif
);

`ifdef DOWNMEM_SAT_EN
  logic [DOWNMEM_LANES-1:0] lane_ovf;

  for (genvar i = 0; i < DOWNMEM_LANES; i++) begin : g_lane
    logic [DOWNMEM_LANE_W:0] wide;
    assign wide = {1'b0, old_line[i*DOWNMEM_LANE_W +: DOWNMEM_LANE_W]}
                + {1'b0, delta[i*DOWNMEM_LANE_W +: DOWNMEM_LANE_W]};
    assign lane_ovf[i] = wide[DOWNMEM_LANE_W];
    assign sum[i*DOWNMEM_LANE_W +: DOWNMEM_LANE_W] =
      wide[DOWNMEM_LANE_W] ? '1 : wide[DOWNMEM_LANE_W-1:0];
  end

  assign sat = |lane_ovf;
`else
  for (genvar i = 0; i < DOWNMEM_LANES; i++) begin : g_lane
    assign sum[i*DOWNMEM_LANE_W +: DOWNMEM_LANE_W] =
      old_line[i*DOWNMEM_LANE_W +: DOWNMEM_LANE_W]
      + delta[i*DOWNMEM_LANE_W +: DOWNMEM_LANE_W];
  end
`endif

endmodule

// File: rtl/downmem_responder.sv
// Backing-memory responder: fixed-latency line read / lane-accumulate write.
// Optional build macro: DOWNMEM_SAT_EN (saturating lanes plus sticky sat output).
module downmem_responder
  import cache_def::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned RD_LAT = 5,
  parameter int unsigned WR_LAT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data_down,
  output logic         busy,
  output logic         err
`ifdef DOWNMEM_SAT_EN
  ,
  output logic         sat
`endif
);

  downmem_state_t state;
  logic [IDX_W-1:0] init_idx;
  logic [7:0]       cnt;
  logic [31:0]      addr_l;
  logic [31:0]      wraddr_l;
  logic [127:0]     data_l;

  logic [127:0]     mem [DEPTH];
  logic             mem_we;
  logic [IDX_W-1:0] mem_wa;
  logic [127:0]     mem_wd;

  logic             rd_oor, wr_oor;
  logic [127:0]     rd_line, wr_old, acc_sum;
`ifdef DOWNMEM_SAT_EN
  logic             acc_sat;
`endif

  assign rd_oor  = addr_l   >= 32'(DEPTH);
  assign wr_oor  = wraddr_l >= 32'(DEPTH);
  assign rd_line = mem[addr_l[IDX_W-1:0]];
  assign wr_old  = mem[wraddr_l[IDX_W-1:0]];
  assign busy    = (state != ST_IDLE);

  downmem_lane_acc u_lane_acc (
    .old_line (wr_old),
    .delta    (data_l),
    .sum      (acc_sum)
`ifdef DOWNMEM_SAT_EN
    ,
    .sat      (acc_sat)
`endif
  );

  // Single write port shared by the INIT sweep and the write completion.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = init_idx;
    mem_wd = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        mem_we = 1'b1;
      end else if (state == ST_WR_WAIT && cnt == '0 && !wr_oor) begin
        mem_we = 1'b1;
        mem_wa = wraddr_l[IDX_W-1:0];
        mem_wd = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      init_idx      <= '0;
      cnt           <= '0;
      addr_l        <= '0;
      wraddr_l      <= '0;
      data_l        <= '0;
      mem_data_down <= '0;
      err           <= 1'b0;
`ifdef DOWNMEM_SAT_EN
      sat           <= 1'b0;
`endif
    end else begin
      mem_data_down.ready <= 1'b0;
      err                 <= 1'b0;
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == IDX_W'(DEPTH - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (mem_req.valid) begin
            addr_l   <= mem_req.addr;
            wraddr_l <= mem_req.wraddr;
            data_l   <= mem_req.data;
            // Loading LAT-1 makes the zero count land exactly on edge k+LAT.
            if (mem_req.rw) begin
              cnt   <= 8'(WR_LAT - 1);
              state <= ST_WR_WAIT;
            end else begin
              cnt   <= 8'(RD_LAT - 1);
              state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt == '0) begin
            mem_data_down.data  <= rd_oor ? '0 : rd_line;
            mem_data_down.ready <= 1'b1;
            err                 <= rd_oor;
            state               <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (cnt == '0) begin
            mem_data_down.ready <= 1'b1;
            err                 <= wr_oor;
`ifdef DOWNMEM_SAT_EN
            if (acc_sat && !wr_oor) sat <= 1'b1;
`endif
            state               <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_downmem_responder.sv
// Directed self-checking bench for downmem_responder (both DOWNMEM_SAT_EN builds).
module tb_downmem_responder;
  import cache_def::*;

  logic         clk = 1'b0;
  logic         rst;
  mem_req_type  mem_req;
  mem_data_type mem_data_down;
  logic         busy;
  logic         err;
`ifdef DOWNMEM_SAT_EN
  logic         sat;
`endif

  int compared   = 0;
  int mismatched = 0;

  downmem_responder #(
    .DEPTH  (128),
    .IDX_W  (7),
    .RD_LAT (5),
    .WR_LAT (7)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_data_down (mem_data_down),
    .busy          (busy),
    .err           (err)
`ifdef DOWNMEM_SAT_EN
    ,
    .sat           (sat)
`endif
  );

  always #5 clk = ~clk;

  // Drive one request, then wait (bounded) for ready; lat=0 means timeout.
  task automatic issue(input bit rw, input logic [31:0] addr, input logic [127:0] wdata,
                       output int lat, output logic [127:0] rdata, output logic e);
    @(negedge clk);
    mem_req.valid  = 1'b1;
    mem_req.rw     = rw;
    mem_req.addr   = addr;
    mem_req.wraddr = addr;
    mem_req.data   = wdata;
    @(posedge clk); #1;
    mem_req.valid = 1'b0;
    lat   = 0;
    rdata = 'x;
    e     = 1'bx;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (mem_data_down.ready) begin
        lat   = i;
        rdata = mem_data_down.data;
        e     = err;
        break;
      end
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n, lat;
    logic [127:0] d;
    logic e;
    rst = 1'b1;
    mem_req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (mem_data_down.ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b expected 0", mem_data_down.ready); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b expected 0", err); end
    compared++; if (mem_data_down.data !== 128'h0) begin mismatched++; $display("FAIL reset_data: got %h expected 0", mem_data_down.data); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL reset_busy: got %b expected 1", busy); end
    rst = 1'b0;
    wait_init(n);
    compared++; if (n !== 128) begin mismatched++; $display("FAIL init_cycles: got %0d expected 128", n); end
    issue(1'b0, 32'd3, '0, lat, d, e);
    compared++; if (lat !== 5) begin mismatched++; $display("FAIL rd3_latency: got %0d expected 5", lat); end
    compared++; if (d !== 128'h0) begin mismatched++; $display("FAIL rd3_data: got %h expected 0", d); end
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL rd3_err: got %b expected 0", e); end
  endtask

  task automatic test_accumulate;
    int lat;
    logic [127:0] d;
    logic e;
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, 32'd5, 128'h10, lat, d, e);
      compared++; if (lat !== 7) begin mismatched++; $display("FAIL wr5_latency: got %0d expected 7", lat); end
      compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL wr5_err: got %b expected 0", e); end
    end
    issue(1'b0, 32'd5, '0, lat, d, e);
    compared++; if (d !== 128'h20) begin mismatched++; $display("FAIL rd5_data: got %h expected %h", d, 128'h20); end
  endtask

  task automatic test_no_carry;
    int lat;
    logic [127:0] d, expd;
    logic e;
    issue(1'b1, 32'd9, {64'h0, 32'hFFFF_FFF0, 32'h0}, lat, d, e);
`ifdef DOWNMEM_SAT_EN
    compared++; if (sat !== 1'b0) begin mismatched++; $display("FAIL sat_before: got %b expected 0", sat); end
`endif
    issue(1'b1, 32'd9, {64'h0, 32'h0000_0020, 32'h0}, lat, d, e);
    issue(1'b0, 32'd9, '0, lat, d, e);
`ifdef DOWNMEM_SAT_EN
    expd = {64'h0, 32'hFFFF_FFFF, 32'h0};
    compared++; if (sat !== 1'b1) begin mismatched++; $display("FAIL sat_after: got %b expected 1", sat); end
`else
    expd = {64'h0, 32'h0000_0010, 32'h0};
`endif
    compared++; if (d !== expd) begin mismatched++; $display("FAIL rd9_lanes: got %h expected %h", d, expd); end
  endtask

  task automatic test_out_of_range;
    int lat;
    logic [127:0] d;
    logic e;
    issue(1'b0, 32'd200, '0, lat, d, e);
    compared++; if (lat !== 5) begin mismatched++; $display("FAIL oor_rd_latency: got %0d expected 5", lat); end
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL oor_rd_err: got %b expected 1", e); end
    compared++; if (d !== 128'h0) begin mismatched++; $display("FAIL oor_rd_data: got %h expected 0", d); end
    issue(1'b1, 32'd200, '1, lat, d, e);
    compared++; if (lat !== 7) begin mismatched++; $display("FAIL oor_wr_latency: got %0d expected 7", lat); end
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL oor_wr_err: got %b expected 1", e); end
    // 200 aliases to index 72 if the upper bits were ignored.
    issue(1'b0, 32'd72, '0, lat, d, e);
    compared++; if (d !== 128'h0) begin mismatched++; $display("FAIL oor_alias72: got %h expected 0", d); end
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL rd72_err: got %b expected 0", e); end
    issue(1'b0, 32'd5, '0, lat, d, e);
    compared++; if (d !== 128'h20) begin mismatched++; $display("FAIL oor_line5: got %h expected %h", d, 128'h20); end
  endtask

  task automatic test_ignored_request;
    int n_ready, first_lat;
    logic [127:0] d;
    n_ready   = 0;
    first_lat = 0;
    d         = 'x;
    @(negedge clk);
    mem_req.valid = 1'b1;
    mem_req.rw    = 1'b0;
    mem_req.addr  = 32'd5;
    @(posedge clk); #1;
    mem_req.valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        mem_req.valid = 1'b1;
        mem_req.addr  = 32'd9;
      end
      if (i == 4) mem_req.valid = 1'b0;
      if (mem_data_down.ready) begin
        n_ready++;
        if (n_ready == 1) begin
          first_lat = i;
          d = mem_data_down.data;
        end
      end
    end
    compared++; if (n_ready !== 1) begin mismatched++; $display("FAIL busy_ignore_count: got %0d expected 1", n_ready); end
    compared++; if (first_lat !== 5) begin mismatched++; $display("FAIL busy_ignore_latency: got %0d expected 5", first_lat); end
    compared++; if (d !== 128'h20) begin mismatched++; $display("FAIL busy_ignore_data: got %h expected %h", d, 128'h20); end
  endtask

  task automatic test_reset_mid_write;
    int n, lat, n_ready;
    logic [127:0] d;
    logic e;
    n_ready = 0;
    @(negedge clk);
    mem_req.valid  = 1'b1;
    mem_req.rw     = 1'b1;
    mem_req.wraddr = 32'd7;
    mem_req.addr   = 32'd7;
    mem_req.data   = 128'h5;
    @(posedge clk); #1;
    mem_req.valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_data_down.ready) n_ready++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_data_down.ready) n_ready++;
    end
    @(negedge clk);
    rst = 1'b0;
    wait_init(n);
    compared++; if (n_ready !== 0) begin mismatched++; $display("FAIL rst_mid_ready: got %0d expected 0", n_ready); end
    compared++; if (n !== 128) begin mismatched++; $display("FAIL rst_mid_init: got %0d expected 128", n); end
    issue(1'b0, 32'd7, '0, lat, d, e);
    compared++; if (d !== 128'h0) begin mismatched++; $display("FAIL rst_mid_line7: got %h expected 0", d); end
    issue(1'b0, 32'd5, '0, lat, d, e);
    compared++; if (d !== 128'h0) begin mismatched++; $display("FAIL rst_mid_line5: got %h expected 0", d); end
  endtask

  initial begin
    test_reset;
    test_accumulate;
    test_no_carry;
    test_out_of_range;
    test_ignored_request;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
